// File: rtl/bus_if_wb_pkg.sv
// Shared definitions for the bus_if_wb CPU-side bus interface.
//   - eng_state_e : bus engine states
//   - SLV_IDX_W   : width of the slave-index field at the top of the word address
//   - READ/WRITE  : rw / bus_rw encodings
//   - ENABLE_/DISABLE_ : levels for the active-low strobes and handshakes
package bus_if_wb_pkg;

    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_REQ   = 2'd1,
        E_ACC   = 2'd2,
        E_STALL = 2'd3
    } eng_state_e;

    // Slave index is addr[ADDR_W-1 -: SLV_IDX_W].
    localparam int unsigned SLV_IDX_W = 3;

    // Timeout counter width; TIMEOUT is limited to 1..255.
    localparam int unsigned TMO_W = 8;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_if_wb_if.sv
// Signal bundle for bus_if_wb: CPU pipeline side, SPM side and shared-bus side.
//   slave  : view used by bus_if_wb (CPU/SPM-data/bus-handshake inputs, the rest outputs)
//   master : view used by the surrounding system / testbench
interface bus_if_wb_if #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32
);
    // CPU side
    logic              stall;
    logic              flush;
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic              as_;
    logic              rw;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              bus_err;
    logic              wb_empty;
    // SPM side
    logic [DATA_W-1:0] spm_rd_data;
    logic [ADDR_W-1:0] spm_addr;
    logic              spm_as_;
    logic              spm_rw;
    logic [DATA_W-1:0] spm_wr_data;
    // Shared bus side
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;
    logic              bus_grnt_;
    logic              bus_req_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;

    modport slave (
        input  stall, flush, addr, as_, rw, wr_data,
               spm_rd_data, bus_rd_data, bus_rdy_, bus_grnt_,
        output busy, rd_data, bus_err, wb_empty,
               spm_addr, spm_as_, spm_rw, spm_wr_data,
               bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
    );

    modport master (
        output stall, flush, addr, as_, rw, wr_data,
               spm_rd_data, bus_rd_data, bus_rdy_, bus_grnt_,
        input  busy, rd_data, bus_err, wb_empty,
               spm_addr, spm_as_, spm_rw, spm_wr_data,
               bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
    );
endinterface

// File: rtl/bus_if_wb_wbuf.sv
// Posted-write buffer: synchronous FIFO of DEPTH entries x WIDTH bits.
//   push/wdata : enqueue (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   head       : oldest entry, valid when !empty
//   count/full/empty : derived from the registered pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bus_if_wbuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 62
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        full     = (count == PTR_W'(DEPTH));
        empty    = (count == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        head     = mem_q[rd_ptr_q[PTR_W-2:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read while count > 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-2:0]] <= wdata;
        end
    end
endmodule

// File: rtl/bus_if_wb.sv
// CPU-side bus interface with posted write buffer.
//   clk, reset (async, active-low)
//   bif (slave modport): CPU request/response, SPM pass-through, shared-bus
//   master handshake, bus_err timeout pulse and wb_empty fence status.
// SPM accesses are zero-wait; off-SPM writes are posted into bus_if_wbuf and
// drained by the bus engine; off-SPM reads wait for an empty buffer (RAW order).
module bus_if_wb
    import bus_if_wb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned WB_DEPTH  = 4,
    parameter int unsigned SPM_INDEX = 1,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    bus_if_wb_if.slave  bif
);
    localparam int unsigned CNT_W = $clog2(WB_DEPTH) + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;
    localparam logic [SLV_IDX_W-1:0] SPM_IDX = SLV_IDX_W'(SPM_INDEX);
    localparam logic [TMO_W-1:0]     TMO     = TMO_W'(TIMEOUT);

    logic             push, pop, wb_full, wb_empty_w;
    logic [ENT_W-1:0] head;
    logic [CNT_W-1:0] wb_count;

    eng_state_e        state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic              bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;

    logic              req_valid, spm_hit, cpu_rd;
    logic              acc_done, acc_tmo;
    logic              busy, spm_as;
    logic [DATA_W-1:0] rd_data;

    bus_if_wbuf #(
        .DEPTH (WB_DEPTH),
        .WIDTH (ENT_W)
    ) u_wbuf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({bif.addr, bif.wr_data}),
        .pop   (pop),
        .head  (head),
        .count (wb_count),
        .full  (wb_full),
        .empty (wb_empty_w)
    );

    always_comb begin
        req_valid     = (bif.as_ == ENABLE_) && !bif.flush;
        spm_hit       = (bif.addr[ADDR_W-1 -: SLV_IDX_W] == SPM_IDX);
        cpu_rd        = req_valid && !spm_hit && (bif.rw == READ);
        acc_done      = 1'b0;
        acc_tmo       = 1'b0;
        rd_data       = '0;
        busy          = 1'b0;
        spm_as        = DISABLE_;
        push          = 1'b0;
        pop           = 1'b0;
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_as_d      = DISABLE_;
        bus_rw_d      = bus_rw_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        bus_err_d     = 1'b0;
        rd_buf_d      = rd_buf_q;
        cnt_d         = cnt_q;

        // CPU request decode
        if (req_valid) begin
            if (spm_hit) begin
                if (!bif.stall) begin
                    spm_as = ENABLE_;
                    if (bif.rw == READ) rd_data = bif.spm_rd_data;
                end
            end else if (bif.rw == WRITE) begin
                // Full check uses the registered count: a pop this cycle
                // does not free a slot until the next one.
                if (wb_full)          busy = 1'b1;
                else if (!bif.stall)  push = 1'b1;
            end else begin
                busy = 1'b1;
            end
        end

        // Bus engine; read completion and E_STALL override the CPU response.
        case (state_q)
            E_IDLE: begin
                if (wb_count != '0) begin
                    state_d       = E_REQ;
                    bus_req_d     = ENABLE_;
                    bus_rw_d      = WRITE;
                    bus_addr_d    = head[ENT_W-1 -: ADDR_W];
                    bus_wr_data_d = head[DATA_W-1:0];
                end else if (cpu_rd) begin
                    state_d       = E_REQ;
                    bus_req_d     = ENABLE_;
                    bus_rw_d      = READ;
                    bus_addr_d    = bif.addr;
                    bus_wr_data_d = bif.wr_data;
                end
            end
            E_REQ: begin
                if (bif.bus_grnt_ == ENABLE_) begin
                    state_d  = E_ACC;
                    bus_as_d = ENABLE_;
                    cnt_d    = '0;
                end
            end
            E_ACC: begin
                acc_done = (bif.bus_rdy_ == ENABLE_);
                acc_tmo  = !acc_done && ((cnt_q + 1'b1) == TMO);
                if (!acc_done) cnt_d = cnt_q + 1'b1;
                if (acc_done || acc_tmo) begin
                    bus_req_d     = DISABLE_;
                    bus_rw_d      = READ;
                    bus_addr_d    = '0;
                    bus_wr_data_d = '0;
                    bus_err_d     = acc_tmo;
                    if (bus_rw_q == WRITE) begin
                        pop     = 1'b1;
                        state_d = E_IDLE;
                    end else begin
                        rd_data  = acc_done ? bif.bus_rd_data : '0;
                        rd_buf_d = rd_data;
                        busy     = 1'b0;
                        state_d  = bif.stall ? E_STALL : E_IDLE;
                    end
                end
            end
            E_STALL: begin
                rd_data = rd_buf_q;
                busy    = 1'b0;
                if (!bif.stall) state_d = E_IDLE;
            end
            default: state_d = E_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= E_IDLE;
            bus_req_q     <= DISABLE_;
            bus_as_q      <= DISABLE_;
            bus_rw_q      <= READ;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            bus_err_q     <= 1'b0;
            rd_buf_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            bus_err_q     <= bus_err_d;
            rd_buf_q      <= rd_buf_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bif.busy        = busy;
    assign bif.rd_data     = rd_data;
    assign bif.bus_err     = bus_err_q;
    assign bif.wb_empty    = wb_empty_w;
    assign bif.spm_addr    = bif.addr;
    assign bif.spm_as_     = spm_as;
    assign bif.spm_rw      = bif.rw;
    assign bif.spm_wr_data = bif.wr_data;
    assign bif.bus_req_    = bus_req_q;
    assign bif.bus_addr    = bus_addr_q;
    assign bif.bus_as_     = bus_as_q;
    assign bif.bus_rw      = bus_rw_q;
    assign bif.bus_wr_data = bus_wr_data_q;
endmodule

// File: tb/tb_bus_if_wb.sv
// Directed testbench for bus_if_wb (WB_DEPTH=4, SPM_INDEX=1, TIMEOUT=8).
// A bus responder logs every bus_as_ strobe and, when enabled, answers with
// bus_rdy_ on the second ACCESS cycle.
module tb_bus_if_wb;
    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_if_wb_if #(.ADDR_W(AW), .DATA_W(DW)) bif();

    bus_if_wb #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .WB_DEPTH  (4),
        .SPM_INDEX (1),
        .TIMEOUT   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif.slave)
    );

    int checks = 0;
    int errors = 0;

    logic          rdy_en    = 1'b1;
    int            rdy_wait  = 1;
    logic [DW-1:0] resp_data = '0;
    int            done_cnt  = 0;
    logic [AW-1:0] log_addr[$];
    logic          log_rw[$];
    logic [DW-1:0] log_data[$];

    // Bus slave responder
    initial begin
        bif.bus_rdy_    = 1'b1;
        bif.bus_rd_data = '0;
        forever begin
            @(negedge clk);
            if (bif.bus_as_ === 1'b0) begin
                log_addr.push_back(bif.bus_addr);
                log_rw.push_back(bif.bus_rw);
                log_data.push_back(bif.bus_wr_data);
                if (rdy_en) begin
                    repeat (rdy_wait) @(posedge clk);
                    #1;
                    bif.bus_rdy_    = 1'b0;
                    bif.bus_rd_data = resp_data;
                    done_cnt++;
                    @(posedge clk);
                    #1;
                    bif.bus_rdy_    = 1'b1;
                    bif.bus_rd_data = 32'h0BAD_0BAD;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic drive(input logic as_n, input logic rw_v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        bif.as_     = as_n;
        bif.rw      = rw_v;
        bif.addr    = a;
        bif.wr_data = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bif.as_ = 1'b1; bif.rw = 1'b1; bif.addr = '0; bif.wr_data = '0;
        bif.stall = 1'b0; bif.flush = 1'b0; bif.spm_rd_data = '0; bif.bus_grnt_ = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bif.bus_req_ !== 1'b1) begin errors++; $display("FAIL reset_bus_req_: got %b expected 1", bif.bus_req_); end
        checks++; if (bif.bus_as_ !== 1'b1) begin errors++; $display("FAIL reset_bus_as_: got %b expected 1", bif.bus_as_); end
        checks++; if (bif.bus_rw !== 1'b1) begin errors++; $display("FAIL reset_bus_rw: got %b expected 1", bif.bus_rw); end
        checks++; if (bif.bus_addr !== 30'h0) begin errors++; $display("FAIL reset_bus_addr: got %h expected 0", bif.bus_addr); end
        checks++; if (bif.bus_wr_data !== 32'h0) begin errors++; $display("FAIL reset_bus_wr_data: got %h expected 0", bif.bus_wr_data); end
        checks++; if (bif.bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b expected 0", bif.bus_err); end
        checks++; if (bif.wb_empty !== 1'b1) begin errors++; $display("FAIL reset_wb_empty: got %b expected 1", bif.wb_empty); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bif.busy); end
        checks++; if (bif.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", bif.rd_data); end
        checks++; if (bif.spm_as_ !== 1'b1) begin errors++; $display("FAIL reset_spm_as_: got %b expected 1", bif.spm_as_); end
        reset = 1'b1;
    endtask

    task automatic test_spm();
        bif.spm_rd_data = 32'hDEAD_BEEF;
        drive(1'b0, 1'b1, 30'h0800_0010, 32'h0);
        @(negedge clk);
        checks++; if (bif.rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL spm_rd_data: got %h expected deadbeef", bif.rd_data); end
        checks++; if (bif.spm_as_ !== 1'b0) begin errors++; $display("FAIL spm_rd_as_: got %b expected 0", bif.spm_as_); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL spm_rd_busy: got %b expected 0", bif.busy); end
        checks++; if (bif.spm_addr !== 30'h0800_0010) begin errors++; $display("FAIL spm_addr: got %h expected 08000010", bif.spm_addr); end
        checks++; if (bif.bus_req_ !== 1'b1) begin errors++; $display("FAIL spm_rd_bus_req_: got %b expected 1", bif.bus_req_); end
        drive(1'b0, 1'b0, 30'h0800_0020, 32'h5555_AAAA);
        @(negedge clk);
        checks++; if (bif.spm_as_ !== 1'b0 || bif.spm_rw !== 1'b0) begin errors++; $display("FAIL spm_wr_strobe: got as_=%b rw=%b expected as_=0 rw=0", bif.spm_as_, bif.spm_rw); end
        checks++; if (bif.spm_wr_data !== 32'h5555_AAAA) begin errors++; $display("FAIL spm_wr_data: got %h expected 5555aaaa", bif.spm_wr_data); end
        checks++; if (bif.busy !== 1'b0 || bif.wb_empty !== 1'b1) begin errors++; $display("FAIL spm_wr_no_post: got busy=%b wb_empty=%b expected 0 1", bif.busy, bif.wb_empty); end
        drive(1'b1, 1'b1, 30'h0, 32'h0);
        @(negedge clk);
        checks++; if (bif.bus_req_ !== 1'b1 || bif.spm_as_ !== 1'b1) begin errors++; $display("FAIL spm_idle: got bus_req_=%b spm_as_=%b expected 1 1", bif.bus_req_, bif.spm_as_); end
    endtask

    task automatic test_back_to_back();
        int base, dbase, n;
        base = log_addr.size(); dbase = done_cnt;
        bif.bus_grnt_ = 1'b0; rdy_en = 1'b1; rdy_wait = 1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 30'h1000_0100 + 30'(i), 32'hA000_0000 + 32'(i));
            @(negedge clk);
            checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_%0d: got %b expected 0", i, bif.busy); end
        end
        drive(1'b1, 1'b1, 30'h0, 32'h0);
        n = 0;
        @(negedge clk);
        while (bif.wb_empty !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL b2b_drain_timeout: got wb_empty=%b expected 1 within 100 cycles", bif.wb_empty); end
        checks++; if (done_cnt - dbase != 4) begin errors++; $display("FAIL b2b_empty_after_4th: got %0d pops expected 4", done_cnt - dbase); end
        checks++; if (log_addr.size() != base + 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", log_addr.size() - base); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[base+i] !== 30'h1000_0100 + 30'(i) || log_rw[base+i] !== 1'b0 || log_data[base+i] !== 32'hA000_0000 + 32'(i)) begin
                errors++; $display("FAIL b2b_order_%0d: got %h/%b/%h expected %h/0/%h", i, log_addr[base+i], log_rw[base+i], log_data[base+i], 30'h1000_0100 + 30'(i), 32'hA000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_wbuf_full();
        int base, n;
        base = log_addr.size();
        bif.bus_grnt_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 30'h1800_0000 + 30'(i), 32'hB000_0000 + 32'(i));
            @(negedge clk);
            checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL full_push_busy_%0d: got %b expected 0", i, bif.busy); end
        end
        drive(1'b0, 1'b0, 30'h1800_0004, 32'hB000_0004);
        @(negedge clk);
        checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL full_5th_busy: got %b expected 1", bif.busy); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL full_hold_busy: got %b expected 1", bif.busy); end
        end
        @(posedge clk); #1; bif.bus_grnt_ = 1'b0;
        n = 0;
        @(negedge clk);
        while (bif.bus_rdy_ !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        checks++; if (n >= 40) begin errors++; $display("FAIL full_rdy_timeout: got no bus_rdy_ expected within 40 cycles"); end
        checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL full_pop_cycle_busy: got %b expected 1", bif.busy); end
        @(negedge clk);
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL full_accept_after_pop: got %b expected 0", bif.busy); end
        drive(1'b1, 1'b1, 30'h0, 32'h0);
        n = 0;
        @(negedge clk);
        while (bif.wb_empty !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++; if (log_addr.size() != base + 5) begin errors++; $display("FAIL full_count: got %0d expected 5", log_addr.size() - base); end
        else for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_addr[base+i] !== 30'h1800_0000 + 30'(i) || log_data[base+i] !== 32'hB000_0000 + 32'(i)) begin
                errors++; $display("FAIL full_order_%0d: got %h/%h expected %h/%h", i, log_addr[base+i], log_data[base+i], 30'h1800_0000 + 30'(i), 32'hB000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_raw_read();
        int base, n;
        base = log_addr.size();
        bif.bus_grnt_ = 1'b0; resp_data = 32'h1234_5678;
        drive(1'b0, 1'b0, 30'h1000_0040, 32'hC000_0000);
        drive(1'b0, 1'b0, 30'h1000_0041, 32'hC000_0001);
        drive(1'b0, 1'b1, 30'h1000_0004, 32'h0);
        n = 0;
        @(negedge clk);
        while (bif.busy !== 1'b0 && n < 80) begin @(negedge clk); n++; end
        checks++; if (n >= 80) begin errors++; $display("FAIL raw_timeout: got busy=%b expected 0 within 80 cycles", bif.busy); end
        checks++; if (bif.bus_rdy_ !== 1'b0) begin errors++; $display("FAIL raw_busy_drop_cycle: got bus_rdy_=%b expected 0", bif.bus_rdy_); end
        checks++; if (bif.rd_data !== 32'h1234_5678) begin errors++; $display("FAIL raw_rd_data: got %h expected 12345678", bif.rd_data); end
        checks++; if (log_addr.size() != base + 3) begin errors++; $display("FAIL raw_count: got %0d expected 3", log_addr.size() - base); end
        else begin
            checks++;
            if (log_addr[base] !== 30'h1000_0040 || log_rw[base] !== 1'b0 || log_addr[base+1] !== 30'h1000_0041 || log_rw[base+1] !== 1'b0) begin
                errors++; $display("FAIL raw_writes_first: got %h/%b %h/%b expected 10000040/0 10000041/0", log_addr[base], log_rw[base], log_addr[base+1], log_rw[base+1]);
            end
            checks++;
            if (log_addr[base+2] !== 30'h1000_0004 || log_rw[base+2] !== 1'b1) begin
                errors++; $display("FAIL raw_read_last: got %h/%b expected 10000004/1", log_addr[base+2], log_rw[base+2]);
            end
        end
        drive(1'b1, 1'b1, 30'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int base, n, acc;
        logic started;
        base = log_addr.size();
        bif.bus_grnt_ = 1'b0; rdy_en = 1'b0;
        drive(1'b0, 1'b1, 30'h1800_0008, 32'h0);
        n = 0; acc = 0; started = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (bif.bus_as_ === 1'b0) started = 1'b1;
            if (started) acc++;
            if (bif.busy === 1'b0) break;
            checks++; if (bif.bus_err !== 1'b0) begin errors++; $display("FAIL tmo_early_err: got %b expected 0", bif.bus_err); end
        end
        checks++; if (n >= 60) begin errors++; $display("FAIL tmo_timeout: got busy=%b expected 0 within 60 cycles", bif.busy); end
        checks++; if (acc != 8) begin errors++; $display("FAIL tmo_acc_cycles: got %0d expected 8", acc); end
        checks++; if (bif.rd_data !== 32'h0) begin errors++; $display("FAIL tmo_rd_data: got %h expected 0", bif.rd_data); end
        drive(1'b1, 1'b1, 30'h0, 32'h0);
        @(negedge clk);
        checks++; if (bif.bus_err !== 1'b1) begin errors++; $display("FAIL tmo_err_pulse: got %b expected 1", bif.bus_err); end
        checks++; if (bif.bus_req_ !== 1'b1) begin errors++; $display("FAIL tmo_bus_req_: got %b expected 1", bif.bus_req_); end
        @(negedge clk);
        checks++; if (bif.bus_err !== 1'b0) begin errors++; $display("FAIL tmo_err_once: got %b expected 0", bif.bus_err); end
        checks++; if (log_addr.size() != base + 1) begin errors++; $display("FAIL tmo_bus_count: got %0d expected 1", log_addr.size() - base); end
        rdy_en = 1'b1;
    endtask

    task automatic test_stall_read();
        int n;
        bif.bus_grnt_ = 1'b0; resp_data = 32'hCAFE_F00D;
        drive(1'b0, 1'b1, 30'h1000_0020, 32'h0);
        n = 0;
        @(negedge clk);
        while (bif.bus_as_ !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n >= 20) begin errors++; $display("FAIL stall_no_access: got no bus_as_ expected within 20 cycles"); end
        @(posedge clk); #1; bif.stall = 1'b1;
        @(negedge clk);
        checks++; if (bif.rd_data !== 32'hCAFE_F00D || bif.busy !== 1'b0) begin errors++; $display("FAIL stall_complete: got %h busy=%b expected cafef00d busy=0", bif.rd_data, bif.busy); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; if (i == 2) bif.stall = 1'b0;
            @(negedge clk);
            checks++; if (bif.rd_data !== 32'hCAFE_F00D || bif.busy !== 1'b0) begin errors++; $display("FAIL stall_hold_%0d: got %h busy=%b expected cafef00d busy=0", i, bif.rd_data, bif.busy); end
        end
        drive(1'b1, 1'b1, 30'h0, 32'h0);
        @(negedge clk);
        checks++; if (bif.rd_data !== 32'h0 || bif.bus_req_ !== 1'b1) begin errors++; $display("FAIL stall_back_idle: got rd_data=%h bus_req_=%b expected 0 1", bif.rd_data, bif.bus_req_); end
    endtask

    task automatic test_flush();
        int base, n;
        base = log_addr.size();
        bif.bus_grnt_ = 1'b1;
        drive(1'b0, 1'b0, 30'h1000_0200, 32'hD000_0000);
        drive(1'b0, 1'b0, 30'h1000_0201, 32'hD000_0001);
        @(posedge clk); #1;
        bif.flush = 1'b1; bif.addr = 30'h1000_0202; bif.wr_data = 32'hD000_0002;
        @(negedge clk);
        checks++; if (bif.busy !== 1'b0 || bif.wb_empty !== 1'b0) begin errors++; $display("FAIL flush_blocked_wr: got busy=%b wb_empty=%b expected 0 0", bif.busy, bif.wb_empty); end
        drive(1'b0, 1'b1, 30'h0800_0000, 32'h0);
        @(negedge clk);
        checks++; if (bif.spm_as_ !== 1'b1 || bif.rd_data !== 32'h0) begin errors++; $display("FAIL flush_blocked_spm: got spm_as_=%b rd_data=%h expected 1 0", bif.spm_as_, bif.rd_data); end
        drive(1'b0, 1'b0, 30'h1000_0202, 32'hD000_0002);
        bif.bus_grnt_ = 1'b0;
        n = 0;
        @(negedge clk);
        while (bif.wb_empty !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL flush_drain_timeout: got wb_empty=%b expected 1 within 100 cycles", bif.wb_empty); end
        checks++; if (log_addr.size() != base + 2) begin errors++; $display("FAIL flush_count: got %0d expected 2", log_addr.size() - base); end
        else begin
            checks++;
            if (log_addr[base] !== 30'h1000_0200 || log_data[base+1] !== 32'hD000_0001) begin
                errors++; $display("FAIL flush_order: got %h/%h expected 10000200/d0000001", log_addr[base], log_data[base+1]);
            end
        end
        @(posedge clk); #1; bif.flush = 1'b0; bif.as_ = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int base;
        bif.bus_grnt_ = 1'b1;
        drive(1'b0, 1'b0, 30'h1000_0300, 32'hE000_0000);
        drive(1'b0, 1'b0, 30'h1000_0301, 32'hE000_0001);
        drive(1'b1, 1'b1, 30'h0, 32'h0);
        @(negedge clk);
        checks++; if (bif.bus_req_ !== 1'b0 || bif.wb_empty !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got bus_req_=%b wb_empty=%b expected 0 0", bif.bus_req_, bif.wb_empty); end
        reset = 1'b0;
        #1;
        checks++; if (bif.bus_req_ !== 1'b1 || bif.wb_empty !== 1'b1) begin errors++; $display("FAIL rstmid_cleared: got bus_req_=%b wb_empty=%b expected 1 1", bif.bus_req_, bif.wb_empty); end
        @(negedge clk);
        reset = 1'b1;
        base = log_addr.size();
        bif.bus_grnt_ = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (log_addr.size() != base || bif.bus_req_ !== 1'b1) begin errors++; $display("FAIL rstmid_lost: got %0d bus accesses bus_req_=%b expected 0 1", log_addr.size() - base, bif.bus_req_); end
    endtask

    initial begin
        test_reset();
        test_spm();
        test_back_to_back();
        test_wbuf_full();
        test_raw_read();
        test_timeout();
        test_stall_read();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
